// File: rtl/div_pkg.sv
// div_pkg: definitions shared by the restoring divider and its step datapath.
//   state_t     : FSM state encoding (IDLE=0, RUN=1, DBZ=2, DONE=3)
//   cnt_width() : step-counter width for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DBZ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The counter runs 0..WIDTH-1, so $clog2(WIDTH) bits are enough.
  // The result is clamped to 1 so that a zero-width vector is never declared.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring trial subtraction (combinational).
//   shifted [WIDTH:0]   : partial remainder after the shift
//   divisor [WIDTH-1:0] : latched divisor
//   diff    [WIDTH:0]   : shifted - {0, divisor}
//   borrow              : 1 when divisor > shifted (that is, no carry-out)
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   diff,
  output logic             borrow
);

  logic [WIDTH+1:0] sum;

  // Two's-complement subtract: add the inverted (WIDTH+1)-bit divisor plus one.
  // A carry out of the top bit means that no borrow occurred.
  assign sum    = {1'b0, shifted} + {1'b0, 1'b1, ~divisor} + (WIDTH+2)'(1);
  assign diff   = sum[WIDTH:0];
  assign borrow = ~sum[WIDTH+1];

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned divider using a start/done handshake.
//   clk, rst : clock; asynchronous active-high reset
//   start    : request a division; sampled only in IDLE or DONE
//   a, b     : dividend and divisor, latched when start is accepted
//   busy     : high while iterating (RUN or DBZ)
//   done     : one-cycle pulse; q, r and dbz are valid
//   q, r     : quotient and remainder, held until the next accepted start
//   dbz      : divide-by-zero flag for the held result
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH:0]   rem_next;
  logic             last_step;

  // The partial remainder always stays below the divisor, so its top bit is
  // never set and is dropped when the next dividend bit is shifted in.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_reg[WIDTH];

  assign shifted = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .shifted (shifted),
    .divisor (divisor_reg),
    .diff    (trial),
    .borrow  (borrow)
  );

  // The quotient bit shifts in where the dividend bit was shifted out.
  assign quo_next  = {quo_reg[WIDTH-2:0], ~borrow};
  assign rem_next  = borrow ? shifted : trial;
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      divisor_reg <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      dbz         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            divisor_reg <= b;
            quo_reg     <= a;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            dbz         <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= (b == '0) ? S_DBZ : S_RUN;
          end else begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
        end

        S_RUN: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_step) begin
            // The outputs are loaded only here, so partial shift state is never visible.
            q         <= quo_next;
            r         <= rem_next[WIDTH-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end

        S_DBZ: begin
          // quo_reg still holds the dividend exactly as it was latched.
          q         <= '1;
          r         <= quo_reg;
          dbz       <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= S_DONE;
        end

        default: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dbz;

  int checks_total = 0;
  int checks_pass  = 0;
  int overlap_cnt  = 0;
  int lat;
  int busy_cnt;

  restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  // busy and done must never be high together.
  always @(negedge clk) if (!rst && busy && done) overlap_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs == exp) checks_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Issue one single-cycle start, then wait (bounded) for done.
  // lat counts rising edges from the accepting edge up to the one after which done is seen.
  task automatic do_div(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                        output int l, output int bc);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 1; bc = 0;
    while (!done && l < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      l++;
    end
    $display("div a=%0d b=%0d -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d",
             ai, bi, q, r, dbz, l, bc);
  endtask

  task automatic check_result(input string tag, input int eq, input int er, input int edbz);
    check({tag, ".q"}, int'(q), eq);
    check({tag, ".r"}, int'(r), er);
    check({tag, ".dbz"}, int'(dbz), edbz);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.q", int'(q), 0);
    check("rst.r", int'(r), 0);
    check("rst.dbz", int'(dbz), 0);
    @(negedge clk);
    rst = 1'b0;

    // 13/3: latency 5, busy for 4 cycles
    do_div(4'd13, 4'd3, lat, busy_cnt);
    check("d13_3.lat", lat, 5);
    check("d13_3.busy", busy_cnt, 4);
    check_result("d13_3", 4, 1, 0);

    do_div(4'd15, 4'd1, lat, busy_cnt);
    check_result("d15_1", 15, 0, 0);
    do_div(4'd2, 4'd7, lat, busy_cnt);
    check_result("d2_7", 0, 2, 0);
    do_div(4'd0, 4'd5, lat, busy_cnt);
    check_result("d0_5", 0, 0, 0);

    // Divide by zero, then a normal division clears dbz.
    do_div(4'd9, 4'd0, lat, busy_cnt);
    check("d9_0.lat", lat, 2);
    check("d9_0.busy", busy_cnt, 1);
    check_result("d9_0", 15, 9, 1);
    do_div(4'd8, 4'd2, lat, busy_cnt);
    check_result("d8_2", 4, 0, 0);

    // start held high: the change of operands mid-run is ignored, and DONE relaunches.
    @(negedge clk);
    a = 4'd14; b = 4'd4; start = 1'b1;
    @(negedge clk);
    a = 4'd6;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    $display("held a=14 b=4 -> q=%0d r=%0d dbz=%0d", q, r, dbz);
    check("held.done", int'(done), 1);
    check_result("held", 3, 2, 0);
    @(posedge clk); #1;
    check("held.relaunch_busy", int'(busy), 1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    $display("relaunch a=6 b=4 -> q=%0d r=%0d dbz=%0d", q, r, dbz);
    check("relaunch.done", int'(done), 1);
    check_result("relaunch", 1, 2, 0);

    // Reset asserted mid-run aborts the division without a done pulse.
    @(negedge clk);
    a = 4'd11; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.busy", int'(busy), 0);
    check("abort.q", int'(q), 0);
    check("abort.r", int'(r), 0);
    check("abort.dbz", int'(dbz), 0);
    busy_cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) busy_cnt++;
    end
    check("abort.no_done", busy_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    do_div(4'd11, 4'd2, lat, busy_cnt);
    check("d11_2.lat", lat, 5);
    check_result("d11_2", 5, 1, 0);

    // Exhaustive sweep against a reference model.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        int eq, er, ed, el;
        if (bi == 0) begin eq = 15; er = ai; ed = 1; el = 2; end
        else begin eq = ai / bi; er = ai % bi; ed = 0; el = 5; end
        do_div(4'(ai), 4'(bi), lat, busy_cnt);
        check($sformatf("sw%0d_%0d.lat", ai, bi), lat, el);
        check_result($sformatf("sw%0d_%0d", ai, bi), eq, er, ed);
      end
    end

    check("busy_done_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
